mc_fsm: RTL and testbench

MC_FSM -- requirements
Module: mc_fsm

---
 rtl/mc_fsm_if.sv | 38 +++
 rtl/mc_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_mc_fsm.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_fsm_if.sv
// Control bus between the multicycle controller and the datapath/memory.
// The master side is the controller: it reads the instruction fields, the
// ALU Zero flag and the memory handshake, and drives every control line.
interface mc_fsm_if;
    // instruction register fields and datapath status
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;

    // control outputs
    logic       PCWrite;
    logic       AdrSrc;
    logic       mem_req;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       trap;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, mem_req, MemWrite, IRWrite, RegWrite, trap,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, mem_req, MemWrite, IRWrite, RegWrite, trap,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state
    );
endinterface

// File: rtl/mc_fsm.sv
// Moore controller for a multicycle RV32I-subset datapath. Memory accesses
// wait on mem_ready; unknown opcodes park the machine in TRAP until reset.
// All write/request enables are forced low while reset is high.
module mc_fsm (
    input  logic     clk,
    input  logic     reset,
    mc_fsm_if.master bus
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
    localparam logic [3:0] JALR     = 4'd11;
    localparam logic [3:0] LUI      = 4'd12;
    localparam logic [3:0] AUIPC    = 4'd13;
    localparam logic [3:0] TRAP     = 4'd14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [2:0] alu_dec;

    logic       pc_write;
    logic       adr_src;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       trap_flag;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [2:0] alu_control;

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ALU operation for register/immediate arithmetic; sub only exists for R-type.
    always_comb begin
        alu_dec = ALU_ADD;
        case (bus.funct3)
            3'b000:  alu_dec = (state_reg == EXECR && bus.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLT;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    end

    // Next-state logic; memory states hold until mem_ready, TRAP holds forever.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:    if (bus.mem_ready) state_next = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECR;
                    OP_ITYPE:          state_next = EXECI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
                    OP_LUI:            state_next = LUI;
                    OP_AUIPC:          state_next = AUIPC;
                    default:           state_next = TRAP;
                endcase
            end
            MEMADR:   state_next = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (bus.mem_ready) state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: if (bus.mem_ready) state_next = FETCH;
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JAL:      state_next = ALUWB;
            JALR:     state_next = JAL;
            LUI:      state_next = FETCH;
            AUIPC:    state_next = ALUWB;
            TRAP:     state_next = TRAP;
            default:  state_next = TRAP;
        endcase
    end

    // Moore output decode; only FETCH's handshake pulses and BRANCH's PC
    // update look at inputs, and those only refine a state-fixed enable.
    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        trap_flag   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 3'b000;
        alu_control = ALU_ADD;
        case (state_reg)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (bus.op == OP_JAL) ? 3'b011 : 3'b010;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = bus.op[5] ? 3'b001 : 3'b000;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = (bus.funct3[2:1] == 2'b00) && (bus.Zero ^ bus.funct3[0]);
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            LUI: begin
                imm_src    = 3'b100;
                result_src = 2'b11;
                reg_write  = 1'b1;
            end
            AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
            end
            TRAP: begin
                trap_flag = 1'b1;
            end
            default: begin
                trap_flag = 1'b0;
            end
        endcase
    end

    // Enables are masked combinationally so nothing writes during reset,
    // even in the middle of a memory wait.
    assign bus.PCWrite    = pc_write  & ~reset;
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.mem_req    = mem_req   & ~reset;
    assign bus.trap       = trap_flag & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_control;
    assign bus.state      = state_reg;
endmodule

// File: tb/tb_mc_fsm.sv
// Randomized bench for mc_fsm: each instruction is expanded into its state
// walk from the instruction class, and every cycle's outputs are compared
// against the control table for that step.
module tb_mc_fsm;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mc_fsm_if bus();

    mc_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0] valid_ops [9];
    logic [2:0] alu_by_f3 [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (op=%b f3=%b t=%0t)",
                     tag, got, exp, bus.op, bus.funct3, $time);
        end
    endtask

    function automatic logic [18:0] get_ctrl();
        return {bus.PCWrite, bus.AdrSrc, bus.mem_req, bus.MemWrite, bus.IRWrite,
                bus.RegWrite, bus.trap, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ImmSrc, bus.ALUControl};
    endfunction

    // Expected control word for one step of an instruction.
    function automatic logic [18:0] exp_ctrl(input int st, input logic mr, input logic zv,
                                             input logic rst);
        logic       pcw, adr, mreq, mw, irw, rw, trp;
        logic [1:0] res, sa, sb;
        logic [2:0] imm, alu;
        {pcw, adr, mreq, mw, irw, rw, trp} = 7'b0;
        res = 2'd0; sa = 2'd0; sb = 2'd0; imm = 3'd0; alu = 3'd0;
        case (st)
            0:  begin mreq = 1; sb = 2; res = 2; irw = mr; pcw = mr; end
            1:  begin sa = 1; sb = 1; imm = (bus.op == OP_JAL) ? 3'd3 : 3'd2; end
            2:  begin sa = 2; sb = 1; imm = bus.op[5] ? 3'd1 : 3'd0; end
            3:  begin adr = 1; mreq = 1; end
            4:  begin res = 1; rw = 1; end
            5:  begin adr = 1; mreq = 1; mw = 1; end
            6:  begin sa = 2; alu = (bus.funct3 == 0 && bus.funct7b5) ? 3'd1 : alu_by_f3[bus.funct3]; end
            7:  begin sa = 2; sb = 1; alu = alu_by_f3[bus.funct3]; end
            8:  begin rw = 1; end
            9:  begin sa = 2; alu = 1; pcw = (bus.funct3[2:1] == 2'b00) && (zv != bus.funct3[0]); end
            10: begin sa = 1; sb = 2; pcw = 1; end
            11: begin sa = 2; sb = 1; end
            12: begin imm = 4; res = 3; rw = 1; end
            13: begin sa = 1; sb = 1; imm = 4; end
            default: trp = 1;
        endcase
        if (rst) {pcw, mreq, mw, irw, rw, trp} = 6'b0;
        return {pcw, adr, mreq, mw, irw, rw, trp, res, sa, sb, imm, alu};
    endfunction

    // One clock: drive inputs after the edge, compare at the falling edge.
    task automatic step(input int st, input logic rst, input logic mr, input logic zv);
        reset         = rst;
        bus.mem_ready = mr;
        bus.Zero      = zv;
        @(negedge clk);
        check("state", {28'd0, bus.state}, st);
        check("ctrl", {13'd0, get_ctrl()}, {13'd0, exp_ctrl(st, mr, zv, rst)});
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH. wmode<0: random waits and noise on
    // mem_ready elsewhere; wmode>=0: fixed memory wait, mem_ready=1 otherwise.
    // zsel 0/1 fixes Zero, 2 randomizes it each cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int zsel, input int wmode);
        int   seq[$];
        int   cycles;
        int   w;
        logic mr;
        logic zv;
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        seq = '{0, 1};
        case (op)
            OP_LOAD:   seq = {seq, 2, 3, 4};
            OP_STORE:  seq = {seq, 2, 5};
            OP_RTYPE:  seq = {seq, 6, 8};
            OP_ITYPE:  seq = {seq, 7, 8};
            OP_BRANCH: seq = {seq, 9};
            OP_JAL:    seq = {seq, 10, 8};
            OP_JALR:   seq = {seq, 11, 10, 8};
            OP_LUI:    seq = {seq, 12};
            OP_AUIPC:  seq = {seq, 13, 8};
            default:   seq = {seq, 14, 14, 14};
        endcase
        cycles = 0;
        foreach (seq[i]) begin
            w = 0;
            if (seq[i] == 3 || seq[i] == 5)
                w = (wmode >= 0) ? wmode : int'($urandom_range(0, 3));
            else if (seq[i] == 0 && wmode < 0)
                w = int'($urandom_range(0, 2));
            for (int k = 0; k <= w; k++) begin
                if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5)
                    mr = (k == w);
                else
                    mr = (wmode >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
                zv = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
                step(seq[i], 1'b0, mr, zv);
                cycles++;
            end
        end
        if (seq[seq.size()-1] == 14) begin
            // trap clears the moment reset rises; FETCH follows the edge
            step(14, 1'b1, 1'b1, 1'b0);
            cycles++;
        end
        $display("instr op=%b f3=%b f7b5=%b cycles=%0d", op, f3, f7, cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] rop;
        int         sel;
        n_checks = 0;
        n_errors = 0;
        valid_ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        // funct3 -> add, sll, slt, slt(u), xor, srl, or, and
        alu_by_f3 = '{3'd0, 3'd6, 3'd5, 3'd5, 3'd4, 3'd7, 3'd3, 3'd2};
        reset        = 1'b1;
        bus.op       = 7'd0;
        bus.funct3   = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.Zero     = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // reset state: FETCH with every enable held low despite mem_ready
        step(0, 1'b1, 1'b1, 1'b0);

        run_instr(OP_RTYPE, 3'b000, 1'b0, 0, 0);   // add
        run_instr(OP_RTYPE, 3'b000, 1'b1, 0, 0);   // sub
        run_instr(OP_LOAD, 3'b010, 1'b0, 0, 3);    // lw, 3 wait cycles
        run_instr(OP_BRANCH, 3'b001, 1'b0, 0, 0);  // bne not equal -> taken
        run_instr(OP_BRANCH, 3'b001, 1'b0, 1, 0);  // bne equal -> not taken
        run_instr(OP_BRANCH, 3'b000, 1'b0, 1, 0);  // beq equal -> taken
        run_instr(OP_BRANCH, 3'b100, 1'b0, 1, 0);  // blt -> never writes PC
        run_instr(OP_JALR, 3'b000, 1'b0, 0, 0);
        run_instr(OP_LUI, 3'b000, 1'b0, 0, 0);
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0); // illegal -> trap

        // reset in the middle of a store wait
        bus.op = OP_STORE; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
        step(0, 1'b0, 1'b1, 1'b0);
        step(1, 1'b0, 1'b1, 1'b0);
        step(2, 1'b0, 1'b1, 1'b0);
        step(5, 1'b0, 1'b0, 1'b0);
        step(5, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0);
        step(1, 1'b0, 1'b1, 1'b0);
        step(2, 1'b0, 1'b1, 1'b0);
        step(5, 1'b0, 1'b1, 1'b0);
        $display("instr op=%b reset during MEMWRITE wait", OP_STORE);

        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 10));
            if (sel < 9) begin
                rop = valid_ops[sel];
            end else begin
                rop = 7'($urandom);
                for (int j = 0; j < 9; j++)
                    if (rop == valid_ops[j]) rop = 7'b1111111;
            end
            run_instr(rop, 3'($urandom), 1'($urandom), 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
